// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Per-register hazard tracker for an in-order issue stage. Each architectural
// register owns a small entry (busy, rem, age) that records an in-flight
// producer: rem counts down to the cycle its result becomes forwardable, age
// counts up from issue and picks the bypass stage that currently holds it.
//
// Decode is held (issue_stall) on a read-after-write hazard against a result
// that is not yet forwardable, or on a write-after-write hazard where the
// older producer would complete after the new one. Sources whose producer is
// complete but not yet written back are reported as bypass hits, together with
// the producer age.
//
// Ports
//   clk             in   clock; every state update on the rising edge
//   rst             in   synchronous active-high reset, overrides issue/flush
//   issue_valid     in   instruction in decode requests issue
//   issue_rs1/rs2   in   source register indices (RW bits)
//   issue_rs1_used  in   rs1 is actually read
//   issue_rs2_used  in   rs2 is actually read
//   issue_rd        in   destination register index (RW bits)
//   issue_wr_rd     in   instruction writes rd
//   issue_lat       in   cycles after issue before the result is forwardable
//   flush           in   redirect; squashes entries younger than FLUSH_DEPTH
//   issue_stall     out  decode held this cycle (combinational)
//   fwd_rs1_hit     out  rs1 served by the bypass network (combinational)
//   fwd_rs2_hit     out  rs2 served by the bypass network (combinational)
//   fwd_rs1_dist    out  age of the rs1 producer when hit, else 0
//   fwd_rs2_dist    out  age of the rs2 producer when hit, else 0
//   stall_cnt       out  saturating count of stalled cycles (registered)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int LAT_W       = 3,
  parameter int RETIRE_AGE  = 3,
  parameter int FLUSH_DEPTH = 2,
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_rs1,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_wr_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush,
  output logic             issue_stall,
  output logic             fwd_rs1_hit,
  output logic             fwd_rs2_hit,
  output logic [LAT_W-1:0] fwd_rs1_dist,
  output logic [LAT_W-1:0] fwd_rs2_dist,
  output logic [31:0]      stall_cnt
);

  // The table is sized to the full index space so any index value selects a
  // real slot; slots at or above NUM_REGS are simply never named by software.
  localparam int SLOTS = 1 << RW;

  localparam logic [LAT_W-1:0] RETIRE_LAST = LAT_W'(RETIRE_AGE - 1);
  localparam logic [LAT_W-1:0] AGE_MAX     = '1;
  localparam logic [LAT_W-1:0] REM_ONE     = LAT_W'(1);

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0] busy;
  logic [LAT_W-1:0] rem [SLOTS];
  logic [LAT_W-1:0] age [SLOTS];

  // ---------------------------------------------------------------------------
  // Source / destination lookups
  // ---------------------------------------------------------------------------
  logic rs1_ready;
  logic rs2_ready;
  logic rs1_fwdable;
  logic rs2_fwdable;
  logic raw_stall;
  logic waw_stall;
  logic accept;
  logic write_en;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here by straight-line assignment); a missing default infers a latch.
  always_comb begin
    // A producer whose result is forwardable no longer blocks its consumers.
    rs1_fwdable = busy[issue_rs1] && (rem[issue_rs1] == '0);
    rs2_fwdable = busy[issue_rs2] && (rem[issue_rs2] == '0);
    rs1_ready   = !busy[issue_rs1] || (rem[issue_rs1] == '0);
    rs2_ready   = !busy[issue_rs2] || (rem[issue_rs2] == '0);

    raw_stall = (issue_rs1_used && !rs1_ready) ||
                (issue_rs2_used && !rs2_ready);

    // The new write must not complete before the older one to the same rd,
    // otherwise the older, stale value would land last.
    waw_stall = issue_wr_rd && (issue_rd != '0) && busy[issue_rd] &&
                (rem[issue_rd] > issue_lat);

    issue_stall = issue_valid && (raw_stall || waw_stall);

    // A redirect drops the instruction in decode even if it could issue.
    accept   = issue_valid && !issue_stall && !flush;
    write_en = accept && issue_wr_rd && (issue_rd != '0);
  end

  // ---------------------------------------------------------------------------
  // Bypass selection
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_rs1_hit  = rs1_fwdable && issue_rs1_used;
    fwd_rs2_hit  = rs2_fwdable && issue_rs2_used;
    fwd_rs1_dist = fwd_rs1_hit ? age[issue_rs1] : '0;
    fwd_rs2_dist = fwd_rs2_hit ? age[issue_rs2] : '0;
  end

  // ---------------------------------------------------------------------------
  // Per-entry release conditions, evaluated on the pre-edge state
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0] squash;
  logic [SLOTS-1:0] retire;

  always_comb begin
    squash = '0;
    retire = '0;
    for (int r = 0; r < SLOTS; r++) begin
      squash[r] = flush && (int'(age[r]) < FLUSH_DEPTH);
      // An entry leaves once it has passed writeback and its result is
      // complete. Long-latency producers reach writeback age before they
      // complete, so the age test is inclusive of older ages; otherwise such
      // an entry would sit in the table forever as a stale bypass hit.
      retire[r] = (age[r] >= RETIRE_LAST) && (rem[r] <= REM_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // entry updates from the same pre-edge snapshot regardless of loop order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is small flop storage, not RAM, so it is cleared
      // outright; that is what makes a reset discard all in-flight work.
      busy      <= '0;
      stall_cnt <= '0;
      for (int r = 0; r < SLOTS; r++) begin
        rem[r] <= '0;
        age[r] <= '0;
      end
    end else begin
      if (issue_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      for (int r = 0; r < SLOTS; r++) begin
        if (write_en && (issue_rd == RW'(r))) begin
          // A new producer replaces whatever was there, including an entry
          // that would have retired on this same edge.
          busy[r] <= 1'b1;
          rem[r]  <= issue_lat;
          age[r]  <= '0;
        end else if (busy[r]) begin
          if (squash[r] || retire[r]) begin
            busy[r] <= 1'b0;
            rem[r]  <= '0;
            age[r]  <= '0;
          end else begin
            rem[r] <= (rem[r] != '0)     ? rem[r] - REM_ONE : '0;
            age[r] <= (age[r] != AGE_MAX) ? age[r] + REM_ONE : AGE_MAX;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Drives directed hazard scenarios followed by randomized traffic. A reference
// model tracks each in-flight producer as (issue edge, latency) and derives
// remaining cycles, age and lifetime arithmetically. The stimulus process
// pushes the model's expected outputs for each cycle into a queue; a monitor
// on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NUM_REGS    = 32;
  localparam int LAT_W       = 3;
  localparam int RETIRE_AGE  = 3;
  localparam int FLUSH_DEPTH = 2;
  localparam int RW          = 5;
  localparam int AGE_SAT     = (1 << LAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [RW-1:0]    issue_rs1;
  logic [RW-1:0]    issue_rs2;
  logic             issue_rs1_used;
  logic             issue_rs2_used;
  logic [RW-1:0]    issue_rd;
  logic             issue_wr_rd;
  logic [LAT_W-1:0] issue_lat;
  logic             flush;
  logic             issue_stall;
  logic             fwd_rs1_hit;
  logic             fwd_rs2_hit;
  logic [LAT_W-1:0] fwd_rs1_dist;
  logic [LAT_W-1:0] fwd_rs2_dist;
  logic [31:0]      stall_cnt;

  hazard_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .LAT_W      (LAT_W),
    .RETIRE_AGE (RETIRE_AGE),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rs1_used(issue_rs1_used),
    .issue_rs2_used(issue_rs2_used),
    .issue_rd      (issue_rd),
    .issue_wr_rd   (issue_wr_rd),
    .issue_lat     (issue_lat),
    .flush         (flush),
    .issue_stall   (issue_stall),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_rs1_dist  (fwd_rs1_dist),
    .fwd_rs2_dist  (fwd_rs2_dist),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a producer is live from its issue edge until it is
  // squashed or its lifetime (cycles until past writeback and complete)
  // expires. Remaining cycles and age are plain differences from issue.
  // ---------------------------------------------------------------------------
  int          m_cyc = 0;
  bit          m_live [NUM_REGS];
  int          m_edge [NUM_REGS];
  int          m_lat  [NUM_REGS];
  logic [31:0] m_cnt  = '0;

  function automatic int m_since(int r);
    return m_cyc - m_edge[r];
  endfunction

  function automatic int m_rem(int r);
    int x;
    if (!m_live[r]) return 0;
    x = m_lat[r] - m_since(r);
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int m_age(int r);
    if (!m_live[r]) return 0;
    return (m_since(r) > AGE_SAT) ? AGE_SAT : m_since(r);
  endfunction

  function automatic bit m_ready(int r);
    return !m_live[r] || (m_rem(r) == 0);
  endfunction

  function automatic bit m_hit(int r, bit used);
    return used && m_live[r] && (m_rem(r) == 0);
  endfunction

  function automatic bit m_stall(bit v, int a, bit au, int b, bit bu,
                                 int d, bit w, int l);
    bit raw, waw;
    raw = (au && !m_ready(a)) || (bu && !m_ready(b));
    waw = w && (d != 0) && m_live[d] && (m_rem(d) > l);
    return v && (raw || waw);
  endfunction

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic model_update();
    bit st, acc;
    int life;
    if (rst) begin
      foreach (m_live[r]) m_live[r] = 1'b0;
      m_cnt = '0;
      m_cyc++;
      return;
    end
    st = m_stall(issue_valid, issue_rs1, issue_rs1_used, issue_rs2,
                 issue_rs2_used, issue_rd, issue_wr_rd, issue_lat);
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    acc = issue_valid && !st && !flush;
    foreach (m_live[r]) begin
      if (m_live[r]) begin
        life = (RETIRE_AGE - 1 > m_lat[r] - 1) ? RETIRE_AGE - 1 : m_lat[r] - 1;
        if ((flush && m_since(r) < FLUSH_DEPTH) || m_since(r) >= life)
          m_live[r] = 1'b0;
      end
    end
    m_cyc++;
    if (acc && issue_wr_rd && issue_rd != 0) begin
      m_live[issue_rd] = 1'b1;
      m_edge[issue_rd] = m_cyc;
      m_lat[issue_rd]  = issue_lat;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard queue and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          stall;
    bit          h1;
    int          d1;
    bit          h2;
    int          d2;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("issue_stall",  issue_stall,  e.stall);
      check("fwd_rs1_hit",  fwd_rs1_hit,  e.h1);
      check("fwd_rs1_dist", fwd_rs1_dist, e.d1);
      check("fwd_rs2_hit",  fwd_rs2_hit,  e.h2);
      check("fwd_rs2_dist", fwd_rs2_dist, e.d2);
      check("stall_cnt",    stall_cnt,    e.cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic apply(input bit r, input bit v, input int a, input bit au,
                       input int b, input bit bu, input int d, input bit w,
                       input int l, input bit f);
    exp_t e;
    rst            = r;
    issue_valid    = v;
    issue_rs1      = RW'(a);
    issue_rs1_used = au;
    issue_rs2      = RW'(b);
    issue_rs2_used = bu;
    issue_rd       = RW'(d);
    issue_wr_rd    = w;
    issue_lat      = LAT_W'(l);
    flush          = f;
    e.stall = m_stall(v, a, au, b, bu, d, w, l);
    e.h1    = m_hit(a, au);
    e.d1    = e.h1 ? m_age(a) : 0;
    e.h2    = m_hit(b, bu);
    e.d2    = e.h2 ? m_age(b) : 0;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  n_stall;
    bit  done;

    rst = 1'b1; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
    issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; issue_rd = '0;
    issue_wr_rd = 1'b0; issue_lat = '0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    idle(); #1;
    check("reset_stall", issue_stall, 0);
    check("reset_cnt", stall_cnt, 0);
    tick();

    // ALU producer followed by a dependent: zero bubbles, bypass at age 0
    apply(0, 1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    apply(0, 1, 5, 1, 0, 0, 0, 0, 0, 0); #1;
    check("alu_dep_stall", issue_stall, 0);
    check("alu_dep_hit", fwd_rs1_hit, 1);
    check("alu_dep_dist", fwd_rs1_dist, 0);
    tick();

    // Load-use: one bubble, then bypass at age 1
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
    apply(0, 1, 0, 0, 7, 1, 0, 0, 0, 0); #1;
    check("load_use_stall", issue_stall, 1);
    tick();
    apply(0, 1, 0, 0, 7, 1, 0, 0, 0, 0); #1;
    check("load_use_release", issue_stall, 0);
    check("load_use_hit", fwd_rs2_hit, 1);
    check("load_use_dist", fwd_rs2_dist, 1);
    check("load_use_cnt", stall_cnt, 1);
    tick();

    // WAW: older rd=3 with lat 4 holds a lat-0 writer of rd=3 for four cycles;
    // rs1 names r3 but is unused and must not add a RAW stall
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 3, 1, 4, 0); tick();
    n_stall = 0;
    done    = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      apply(0, 1, 3, 0, 3, 0, 3, 1, 0, 0); #1;
      if (issue_stall) n_stall++;
      else done = 1'b1;
      tick();
    end
    check("waw_accepted", done, 1);
    check("waw_stall_cycles", n_stall, 4);
    idle(); #1;
    check("waw_cnt", stall_cnt, 4);
    tick();

    // Flush: rd=9 at age 2 survives, rd=4 at age 0 is squashed, the issuing
    // rd=6 in the flush cycle is dropped
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 9, 1, 4, 0); tick();
    idle(); tick();
    apply(0, 1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
    apply(0, 1, 0, 0, 0, 0, 6, 1, 0, 1); tick();
    apply(0, 1, 9, 1, 4, 1, 0, 0, 0, 0); #1;
    check("flush_old_kept", issue_stall, 1);
    check("flush_young_gone", fwd_rs2_hit, 0);
    tick();
    apply(0, 0, 6, 1, 6, 1, 0, 0, 0, 0); #1;
    check("flush_issue_dropped", fwd_rs1_hit, 0);
    tick();

    // x0 never becomes busy; rd=8 lat 0 is forwardable for RETIRE_AGE cycles
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 0, 1, 2, 0); tick();
    apply(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    check("x0_stall", issue_stall, 0);
    check("x0_hit", fwd_rs1_hit, 0);
    tick();
    apply(0, 1, 0, 0, 0, 0, 8, 1, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 8, 1, 0, 0, 0, 0, 0, 0); #1;
      check("retire_hit", fwd_rs1_hit, (i < RETIRE_AGE) ? 1 : 0);
      check("retire_dist", fwd_rs1_dist, (i < RETIRE_AGE) ? i : 0);
      tick();
    end

    // Reset in the middle of a stall discards the pending producer
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 2, 1, 3, 0); tick();
    apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 0); #1;
    check("mid_stall_before", issue_stall, 1);
    tick();
    apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 2, 1, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 0); #1;
    check("mid_stall_after", issue_stall, 0);
    check("mid_stall_cnt", stall_cnt, 0);
    tick();

    // Randomized traffic over a small register window to force collisions
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 5),
            ($urandom_range(0, 9) == 0));
      tick();
    end

    idle(); tick();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
